// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the program-counter stage.
//   pc_state_t : control FSM state encoding (BOOT, RUN, HALT, FAULT)
//   ADDR_W     : program-counter width in bits
//   PC_INC     : sequential PC increment (one 32-bit instruction)
//   pc_aligned : true when an address is a legal 4-byte instruction address
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int ADDR_W = 64;
    localparam logic [ADDR_W-1:0] PC_INC = 64'd4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } pc_state_t;

    function automatic logic pc_aligned(input logic [ADDR_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl_if
// Bundle between the core control logic (master) and the PC stage (slave).
//   master drives : stall, halt_req, resume, br_cond_taken, uncond_br, br_reg,
//                   imm19, imm26, reg_target
//   slave drives  : pc, pc_plus4, fetch_valid, misalign_err, state
// -----------------------------------------------------------------------------
interface pc_fetch_ctrl_if;
    import cpu_pkg::*;

    logic              stall;
    logic              halt_req;
    logic              resume;
    logic              br_cond_taken;
    logic              uncond_br;
    logic              br_reg;
    logic [18:0]       imm19;
    logic [25:0]       imm26;
    logic [ADDR_W-1:0] reg_target;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              fetch_valid;
    logic              misalign_err;
    logic [1:0]        state;

    modport master (
        output stall, halt_req, resume, br_cond_taken, uncond_br, br_reg,
               imm19, imm26, reg_target,
        input  pc, pc_plus4, fetch_valid, misalign_err, state
    );

    modport slave (
        input  stall, halt_req, resume, br_cond_taken, uncond_br, br_reg,
               imm19, imm26, reg_target,
        output pc, pc_plus4, fetch_valid, misalign_err, state
    );

endinterface

// File: rtl/adder64.sv
// -----------------------------------------------------------------------------
// adder64
// 64-bit ripple-carry adder, sum modulo 2^64 (carry-out discarded).
//   a_i, b_i : operands
//   sum_o    : a_i + b_i
// -----------------------------------------------------------------------------
module adder64
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0] a_i,
    input  logic [ADDR_W-1:0] b_i,
    output logic [ADDR_W-1:0] sum_o
);

    logic carry_s;

    // Bit-serial carry chain; the final carry simply falls off the top.
    always_comb begin
        carry_s = 1'b0;
        sum_o   = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry_s;
            carry_s  = (a_i[i] & b_i[i]) | (carry_s & (a_i[i] ^ b_i[i]));
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl_branch_target_gen.sv
// -----------------------------------------------------------------------------
// branch_target_gen
// Forms the two PC-relative branch targets from the current PC.
//   pc_i            : current PC
//   imm19_i         : signed word offset of a conditional branch
//   imm26_i         : signed word offset of an unconditional branch
//   cond_target_o   : pc + (sext(imm19) << 2)
//   uncond_target_o : pc + (sext(imm26) << 2)
// -----------------------------------------------------------------------------
module branch_target_gen
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [18:0]       imm19_i,
    input  logic [25:0]       imm26_i,
    output logic [ADDR_W-1:0] cond_target_o,
    output logic [ADDR_W-1:0] uncond_target_o
);

    // Word offsets become byte offsets: sign bit replicated above, two zero
    // bits appended below. Negative offsets then wrap through the adder.
    logic [ADDR_W-1:0] cond_off_s;
    logic [ADDR_W-1:0] uncond_off_s;

    assign cond_off_s   = {{43{imm19_i[18]}}, imm19_i, 2'b00};
    assign uncond_off_s = {{36{imm26_i[25]}}, imm26_i, 2'b00};

    adder64 u_cond_add (
        .a_i   (pc_i),
        .b_i   (cond_off_s),
        .sum_o (cond_target_o)
    );

    adder64 u_uncond_add (
        .a_i   (pc_i),
        .b_i   (uncond_off_s),
        .sum_o (uncond_target_o)
    );

endmodule

// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
// Program-counter stage: holds the PC, selects the next PC (register-indirect,
// unconditional, conditional or sequential) and runs the boot/halt/fault FSM.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : pc_fetch_ctrl_if.slave (control inputs, pc/status outputs)
// Parameter RESET_VEC : PC loaded on reset (must be 4-byte aligned).
// -----------------------------------------------------------------------------
module pc_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VEC = 64'h0
) (
    input  logic                 clk,
    input  logic                 reset,
    pc_fetch_ctrl_if.slave       bus
);

    pc_state_t         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] pc_plus4_s;
    logic [ADDR_W-1:0] cond_target_s;
    logic [ADDR_W-1:0] uncond_target_s;

    adder64 u_seq_add (
        .a_i   (pc_q),
        .b_i   (PC_INC),
        .sum_o (pc_plus4_s)
    );

    branch_target_gen u_btg (
        .pc_i            (pc_q),
        .imm19_i         (bus.imm19),
        .imm26_i         (bus.imm26),
        .cond_target_o   (cond_target_s),
        .uncond_target_o (uncond_target_s)
    );

    // Next-state, next-PC and fault-flag selection.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (bus.halt_req) begin
                    state_d = HALT;
                end else if (bus.stall) begin
                    state_d = RUN;
                end else if (bus.br_reg) begin
                    // A misaligned indirect target never reaches the PC.
                    if (pc_aligned(bus.reg_target)) begin
                        pc_d = bus.reg_target;
                    end else begin
                        state_d = FAULT;
                        err_d   = 1'b1;
                    end
                end else if (bus.uncond_br) begin
                    pc_d = uncond_target_s;
                end else if (bus.br_cond_taken) begin
                    pc_d = cond_target_s;
                end else begin
                    pc_d = pc_plus4_s;
                end
            end
            HALT: begin
                // A simultaneous halt_req keeps the core parked.
                if (bus.resume && !bus.halt_req) begin
                    state_d = RUN;
                end else begin
                    state_d = HALT;
                end
            end
            FAULT: begin
                err_d = 1'b1;
            end
            default: begin
                state_d = FAULT;
                err_d   = 1'b1;
            end
        endcase
    end

    // PC, FSM state and sticky fault flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_plus4     = pc_plus4_s;
    assign bus.fetch_valid  = (state_q == RUN);
    assign bus.misalign_err = err_q;
    assign bus.state        = state_q;

endmodule
